// File: rtl/sram_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_ctrl
// Purpose  : March C- BIST sequencer for a single-port SRAM macro with
//            programmable data background; optional SRAM_MARCH_STOP_ON_FAIL_EN
//            ends the run at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module sram_march_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              sram_men,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [7:0]        fail_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_last = '1;
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
  localparam logic [2:0]        c_elem_last = 3'd5;
  localparam logic [7:0]        c_cnt_max   = 8'hFF;

  // Elements 1..4 are read-then-write pairs; 3 and 4 walk downwards.
  function automatic logic f_pair(input logic [2:0] e);
    return (e != 3'd0) && (e != c_elem_last);
  endfunction

  function automatic logic f_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic f_read(input logic [2:0] e, input logic ph);
    return (e == c_elem_last) || (f_pair(e) && !ph);
  endfunction

  function automatic logic [DATA_W-1:0] f_data(input logic [2:0] e, input logic ph,
                                               input logic [DATA_W-1:0] p);
    logic inv;
    inv = ((e == 3'd1) || (e == 3'd3)) ? ph :
          ((e == 3'd2) || (e == 3'd4)) ? !ph : 1'b0;
    return inv ? ~p : p;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_elem, w_elem_nxt;
  logic              r_phase, w_phase_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_pat, w_pat_nxt;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [DATA_W-1:0] r_cmp_exp;

  logic              w_term, w_run_nxt, w_ren_nxt, w_wen_nxt;
  logic [DATA_W-1:0] w_din_nxt;
  logic [ADDR_W-1:0] w_maddr_nxt;
  logic              w_mis, w_first, w_count, w_stop;
  logic [7:0]        w_cnt_nxt;

  assign w_term  = f_down(r_elem) ? (r_addr == '0) : (r_addr == c_addr_last);
  assign w_mis   = r_cmp_valid && (sram_dout != r_cmp_exp);
  assign w_first = w_mis && (fail_cnt == 8'd0);

`ifdef SRAM_MARCH_STOP_ON_FAIL_EN
  assign w_count = w_first;
  assign w_stop  = w_first;
`else
  assign w_count = w_mis;
  assign w_stop  = 1'b0;
`endif

  assign w_cnt_nxt = (w_count && (fail_cnt != c_cnt_max)) ? fail_cnt + 8'd1 : fail_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_phase_nxt = r_phase;
    w_addr_nxt  = r_addr;
    w_pat_nxt   = r_pat;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pat_nxt   = pattern;
          w_elem_nxt  = 3'd0;
          w_phase_nxt = 1'b0;
          w_addr_nxt  = '0;
        end
      end
      S_RUN: begin
        if (w_stop) begin
          w_state_nxt = S_DRAIN;
        end else if (f_pair(r_elem) && !r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          if (w_term) begin
            if (r_elem == c_elem_last) begin
              w_state_nxt = S_DRAIN;
            end else begin
              w_elem_nxt = r_elem + 3'd1;
              w_addr_nxt = f_down(r_elem + 3'd1) ? c_addr_last : '0;
            end
          end else begin
            w_addr_nxt = f_down(r_elem) ? r_addr - c_addr_one : r_addr + c_addr_one;
          end
        end
      end
      S_DRAIN: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Macro controls are decoded from next-state so they leave straight from flops.
  assign w_run_nxt   = (w_state_nxt == S_RUN);
  assign w_ren_nxt   = w_run_nxt && f_read(w_elem_nxt, w_phase_nxt);
  assign w_wen_nxt   = w_run_nxt && !f_read(w_elem_nxt, w_phase_nxt);
  assign w_din_nxt   = w_wen_nxt ? f_data(w_elem_nxt, w_phase_nxt, w_pat_nxt) : '0;
  assign w_maddr_nxt = w_run_nxt ? w_addr_nxt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_elem      <= '0;
      r_phase     <= 1'b0;
      r_addr      <= '0;
      r_pat       <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_exp   <= '0;
      sram_men    <= 1'b0;
      sram_wen    <= 1'b0;
      sram_ren    <= 1'b0;
      sram_addr   <= '0;
      sram_din    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_exp    <= '0;
      fail_got    <= '0;
      fail_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_elem      <= w_elem_nxt;
      r_phase     <= w_phase_nxt;
      r_addr      <= w_addr_nxt;
      r_pat       <= w_pat_nxt;
      sram_men    <= w_run_nxt;
      sram_wen    <= w_wen_nxt;
      sram_ren    <= w_ren_nxt;
      sram_addr   <= w_maddr_nxt;
      sram_din    <= w_din_nxt;
      busy        <= w_run_nxt || (w_state_nxt == S_DRAIN);
      done        <= (w_state_nxt == S_DONE);
      // The read issued this cycle is checked against sram_dout next cycle.
      r_cmp_valid <= sram_ren;
      r_cmp_addr  <= sram_addr;
      r_cmp_exp   <= f_data(r_elem, r_phase, r_pat);
      if ((r_state == S_IDLE) && start) begin
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
        fail_cnt  <= '0;
        pass      <= 1'b0;
      end else begin
        fail_cnt <= w_cnt_nxt;
        if (w_first) begin
          fail_addr <= r_cmp_addr;
          fail_exp  <= r_cmp_exp;
          fail_got  <= sram_dout;
        end
        if (w_state_nxt == S_DONE) begin
          pass <= (w_cnt_nxt == 8'd0);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_march_ctrl
// Purpose  : Scoreboard bench for sram_march_ctrl with a behavioural SRAM
//            (optional stuck-at bit) and a March C- reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_march_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int N      = 1 << ADDR_W;
  localparam int C_OPS  = 10 * N;
`ifdef SRAM_MARCH_STOP_ON_FAIL_EN
  localparam bit C_STOP = 1'b1;
`else
  localparam bit C_STOP = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] C_FAULT_ADDR = 10'h155;
  localparam logic [DATA_W-1:0] C_FAULT_MASK = 8'h08;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] pattern = '0;
  logic              sram_men, sram_wen, sram_ren;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout = '0;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_exp, fail_got;
  logic [7:0]        fail_cnt;
  logic [57:0]       all_out;

  sram_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .fail_cnt(fail_cnt)
  );

  assign all_out = {sram_men, sram_wen, sram_ren, sram_addr, sram_din, busy, done, pass,
                    fail_addr, fail_exp, fail_got, fail_cnt};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural macro, 1-cycle read latency, optional stuck-at-1 bit.
  logic [DATA_W-1:0] mem [N];
  bit fault_en = 1'b0;
  always @(posedge clk) begin
    if (sram_men && sram_ren)
      sram_dout <= mem[sram_addr] |
                   ((fault_en && (sram_addr == C_FAULT_ADDR)) ? C_FAULT_MASK : 8'h00);
    if (sram_men && sram_wen)
      mem[sram_addr] <= sram_din;
  end

  typedef struct {
    int                cyc;
    bit                wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } op_t;

  typedef struct {
    int                acc;
    int                done_cyc;
    bit                pass;
    logic [ADDR_W-1:0] faddr;
    logic [DATA_W-1:0] fexp;
    logic [DATA_W-1:0] fgot;
    logic [7:0]        fcnt;
  } res_t;

  op_t  oq[$];
  res_t rq[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h required=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // March C- table: 0 none, 1 read P, 2 read ~P, 3 write P, 4 write ~P
  function automatic int march_op(input int e, input int o);
    case (e)
      0:       return (o == 0) ? 3 : 0;
      1:       return (o == 0) ? 1 : 4;
      2:       return (o == 0) ? 2 : 3;
      3:       return (o == 0) ? 1 : 4;
      4:       return (o == 0) ? 2 : 3;
      default: return (o == 0) ? 1 : 0;
    endcase
  endfunction

  // Walks the whole test on an ideal array and queues the expected port ops and result.
  task automatic build_run(input logic [DATA_W-1:0] p, input bit flt, input int acc);
    logic [DATA_W-1:0] rm [N];
    logic [DATA_W-1:0] d, got;
    op_t  ops[$];
    op_t  op;
    res_t r;
    int   k, cnt, idx, code, a, nkeep, done_off;
    k = -1; cnt = 0; idx = 0;
    r.acc = acc; r.faddr = '0; r.fexp = '0; r.fgot = '0;
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < N; j++) begin
        a = (e == 3 || e == 4) ? (N - 1 - j) : j;
        for (int o = 0; o < 2; o++) begin
          code = march_op(e, o);
          if (code != 0) begin
            d = (code == 2 || code == 4) ? ~p : p;
            op.cyc  = acc + idx;
            op.addr = a[ADDR_W-1:0];
            if (code >= 3) begin
              op.wen = 1'b1; op.din = d; rm[a] = d;
            end else begin
              op.wen = 1'b0; op.din = '0;
              got = rm[a] | ((flt && (a == int'(C_FAULT_ADDR))) ? C_FAULT_MASK : 8'h00);
              if (got != d) begin
                if (cnt == 0) begin
                  k = idx; r.faddr = a[ADDR_W-1:0]; r.fexp = d; r.fgot = got;
                end
                if (cnt < 255) cnt++;
              end
            end
            ops.push_back(op);
            idx++;
          end
        end
      end
    end
    nkeep = C_OPS; done_off = C_OPS + 2;
    if (C_STOP && cnt > 0) begin
      cnt = 1;
      if (k + 1 < C_OPS) begin
        nkeep = k + 2; done_off = k + 4;
      end
    end
    r.fcnt = cnt[7:0];
    r.pass = (cnt == 0);
    r.done_cyc = acc + done_off - 1;
    for (int i = 0; i < nkeep; i++) oq.push_back(ops[i]);
    rq.push_back(r);
  endtask

  always @(negedge clk) begin : mon
    op_t  e;
    res_t r;
    bit   exp_busy;
    if (!rst) begin
      if (oq.size() > 0 && oq[0].cyc == cyc) begin
        e = oq.pop_front();
        chk("macro_op", 64'({sram_men, sram_wen, sram_ren, sram_addr, sram_din}),
            64'({1'b1, e.wen, ~e.wen, e.addr, e.din}));
      end else begin
        chk("macro_quiet", 64'({sram_men, sram_wen, sram_ren, sram_addr, sram_din}), 64'(0));
      end
      exp_busy = (rq.size() > 0) && (cyc >= rq[0].acc) && (cyc < rq[0].done_cyc);
      chk("busy", 64'(busy), 64'(exp_busy));
      if (done) begin
        if (rq.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'(0));
        end else begin
          r = rq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(r.done_cyc));
          chk("pass", 64'(pass), 64'(r.pass));
          chk("fail_addr", 64'(fail_addr), 64'(r.faddr));
          chk("fail_exp", 64'(fail_exp), 64'(r.fexp));
          chk("fail_got", 64'(fail_got), 64'(r.fgot));
          chk("fail_cnt", 64'(fail_cnt), 64'(r.fcnt));
        end
      end else if (rq.size() > 0 && cyc >= rq[0].done_cyc) begin
        chk("done_missing", 64'(done), 64'(1));
        void'(rq.pop_front());
      end
    end
  end

  task automatic start_run(input logic [DATA_W-1:0] p, input bit flt, output int acc);
    @(negedge clk);
    fault_en = flt;
    pattern  = p;
    start    = 1'b1;
    acc      = cyc + 1;
    build_run(p, flt, acc);
  endtask

  task automatic drop_start();
    @(negedge clk);
    start   = 1'b0;
    pattern = DATA_W'($urandom);
  endtask

  task automatic wait_done(output int dcyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < C_OPS + 60) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, n);
    end
    dcyc = cyc;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc, dc, acc2;
    logic [DATA_W-1:0] p;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'(all_out), 64'(0));
    #2 rst = 1'b0;

    // Clean run with all-zero background
    start_run(8'h00, 1'b0, acc);
    drop_start();
    wait_done(dc);
    chk("clean_done_cycle", 64'(dc - acc + 1), 64'(C_OPS + 2));
    chk("clean_pass", 64'(pass), 64'(1));

    // Checkerboard-ish background
    gap();
    start_run(8'hA5, 1'b0, acc);
    drop_start();
    wait_done(dc);
    chk("a5_pass", 64'(pass), 64'(1));

    // Stuck-at-1 on bit 3 of 0x155
    gap();
    start_run(8'h00, 1'b1, acc);
    drop_start();
    wait_done(dc);
    chk("fault_pass", 64'(pass), 64'(0));
    chk("fault_addr", 64'(fail_addr), 64'(C_FAULT_ADDR));
    chk("fault_exp", 64'(fail_exp), 64'(0));
    chk("fault_got", 64'(fail_got), 64'(C_FAULT_MASK));
    chk("fault_cnt", 64'(fail_cnt), 64'(C_STOP ? 1 : 3));
    chk("fault_done_cycle", 64'(dc - acc + 1),
        64'(C_STOP ? (N + 2 * int'(C_FAULT_ADDR) + 4) : (C_OPS + 2)));

    // Abort with reset in cycle 5000
    gap();
    p = DATA_W'($urandom);
    start_run(p, 1'b0, acc);
    drop_start();
    while (cyc < acc + 4999) @(negedge clk);
    #2 rst = 1'b1;
    oq.delete();
    rq.delete();
    #1 chk("abort_outputs", 64'(all_out), 64'(0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Clean run after abort
    p = DATA_W'($urandom);
    start_run(p, 1'b0, acc);
    drop_start();
    wait_done(dc);
    chk("post_abort_done_cycle", 64'(dc - acc + 1), 64'(C_OPS + 2));
    chk("post_abort_pass", 64'(pass), 64'(1));

    // Start pulsed during RUN must be ignored
    gap();
    p = DATA_W'($urandom);
    start_run(p, 1'b0, acc);
    drop_start();
    repeat ($urandom_range(50, 9000)) @(negedge clk);
    start   = 1'b1;
    pattern = DATA_W'($urandom);
    @(negedge clk);
    start   = 1'b0;
    wait_done(dc);
    chk("ignored_start_done_cycle", 64'(dc - acc + 1), 64'(C_OPS + 2));

    // Start held: faulty run, then back-to-back clean run
    gap();
    p = DATA_W'($urandom);
    start_run(p, 1'b1, acc);
    wait_done(dc);
    fault_en = 1'b0;
    p        = DATA_W'($urandom);
    pattern  = p;
    acc2     = dc + 2;
    build_run(p, 1'b0, acc2);
    @(negedge clk);
    @(negedge clk);
    chk("reaccept_busy", 64'(busy), 64'(1));
    chk("reaccept_status_clear", 64'({pass, fail_addr, fail_exp, fail_got, fail_cnt}), 64'(0));
    start = 1'b0;
    wait_done(dc);
    chk("b2b_done_cycle", 64'(dc - acc2 + 1), 64'(C_OPS + 2));
    chk("b2b_pass", 64'(pass), 64'(1));

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(oq.size() + rq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
